// File: rtl/modulo_envase_rolhas_param.sv
// Bottling-line controller: fill/seal FSM, cork stock with saturation reject, bottle/dozen counters.
// Optional build macro AUTO_REFILL_EN: requests a refill internally whenever stock drops below STOCK_MIN.
module modulo_envase_rolhas_param #(
    parameter int STOCK_W    = 7,
    parameter int STOCK_MAX  = 99,
    parameter int STOCK_MIN  = 5,
    parameter int REFILL_QTY = 15,
    parameter int DOZEN      = 12,
    parameter int DUZ_W      = 4,
    parameter int DUZ_MAX    = 10
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start_stop,
    input  logic               pg,
    input  logic               ch,
    input  logic               cq,
    input  logic               add_rolhas,
    output logic               m,
    output logic               ev,
    output logic               ve,
    output logic               al,
    output logic               refill_req,
    output logic               add_reject,
    output logic [1:0]         estado,
    output logic [STOCK_W-1:0] rolhas,
    output logic [3:0]         garrafas,
    output logic [DUZ_W-1:0]   duzias
);

    typedef enum logic [1:0] {
        PARADO     = 2'b00,
        TRANSPORTE = 2'b01,
        ENCHIMENTO = 2'b10,
        VEDACAO    = 2'b11
    } state_t;

    localparam logic [STOCK_W:0]   MAX_EXT  = (STOCK_W+1)'(STOCK_MAX);
    localparam logic [STOCK_W:0]   QTY_EXT  = (STOCK_W+1)'(REFILL_QTY);
    localparam logic [STOCK_W-1:0] MIN_W    = STOCK_W'(STOCK_MIN);
    localparam logic [3:0]         DOZ_LAST = 4'(DOZEN - 1);
    localparam logic [DUZ_W-1:0]   DUZ_LAST = DUZ_W'(DUZ_MAX - 1);

    state_t             state_q, state_d;
    logic [STOCK_W-1:0] rolhas_q, rolhas_d;
    logic [3:0]         garrafas_q, garrafas_d;
    logic [DUZ_W-1:0]   duzias_q, duzias_d;
    logic               reject_q, reject_d;
    logic               m_q, m_d;
    logic               ev_q, ev_d;
    logic               ve_q, ve_d;

    logic               dec;
    logic               inc;
    logic [STOCK_W:0]   after_dec;
    logic [STOCK_W:0]   sum;

    always_comb begin
        state_d = state_q;
        if (!start_stop) begin
            state_d = PARADO;
        end else begin
            unique case (state_q)
                PARADO:     state_d = TRANSPORTE;
                TRANSPORTE: if (pg) state_d = ENCHIMENTO;
                // An empty stock parks the line at the filler until corks arrive
                ENCHIMENTO: if (ch && (rolhas_q != '0)) state_d = VEDACAO;
                VEDACAO:    state_d = TRANSPORTE;
                default:    state_d = PARADO;
            endcase
        end
    end

    always_comb begin
        dec = (state_q == VEDACAO);
`ifdef AUTO_REFILL_EN
        inc = add_rolhas | (rolhas_q < MIN_W);
`else
        inc = add_rolhas;
`endif
        after_dec = {1'b0, rolhas_q} - {{STOCK_W{1'b0}}, dec};
        sum       = after_dec + (inc ? QTY_EXT : '0);
        rolhas_d  = sum[STOCK_W-1:0];
        reject_d  = 1'b0;
        // An add that would overshoot is dropped whole; the consume still happens
        if (inc && (sum > MAX_EXT)) begin
            rolhas_d = after_dec[STOCK_W-1:0];
            reject_d = 1'b1;
        end
    end

    always_comb begin
        garrafas_d = garrafas_q;
        duzias_d   = duzias_q;
        if ((state_q == VEDACAO) && cq) begin
            if (garrafas_q == DOZ_LAST) begin
                garrafas_d = '0;
                duzias_d   = (duzias_q == DUZ_LAST) ? '0 : duzias_q + 1'b1;
            end else begin
                garrafas_d = garrafas_q + 1'b1;
            end
        end
    end

    always_comb begin
        m_d  = (state_d == TRANSPORTE);
        ev_d = (state_d == ENCHIMENTO) && (rolhas_d != '0);
        ve_d = (state_d == VEDACAO);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= PARADO;
            rolhas_q   <= '0;
            garrafas_q <= '0;
            duzias_q   <= '0;
            reject_q   <= 1'b0;
            m_q        <= 1'b0;
            ev_q       <= 1'b0;
            ve_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rolhas_q   <= rolhas_d;
            garrafas_q <= garrafas_d;
            duzias_q   <= duzias_d;
            reject_q   <= reject_d;
            m_q        <= m_d;
            ev_q       <= ev_d;
            ve_q       <= ve_d;
        end
    end

    assign estado     = state_q;
    assign rolhas     = rolhas_q;
    assign garrafas   = garrafas_q;
    assign duzias     = duzias_q;
    assign add_reject = reject_q;
    assign m          = m_q;
    assign ev         = ev_q;
    assign ve         = ve_q;
    assign al         = (rolhas_q == '0);
    assign refill_req = (rolhas_q < MIN_W);

endmodule
